// File: rtl/core_int_ctrl_if.sv
// Interrupt offer handshake between the machine-mode interrupt controller
// (master) and the writeback stage (slave).
interface core_int_ctrl_if #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 6
);
  logic               int_pending;
  logic               int_request;
  logic [CAUSE_W-1:0] int_cause;
  logic [XLEN-1:0]    int_tvec;
  logic               int_ack;

  modport master (
    output int_pending, int_request, int_cause, int_tvec,
    input  int_ack
  );

  modport slave (
    input  int_pending, int_request, int_cause, int_tvec,
    output int_ack
  );
endinterface

// File: rtl/core_int_ctrl.sv
// Machine-mode interrupt controller: syncs and latches sources, gates them with
// mie / mstatus.MIE / privilege, and offers one locked interrupt to writeback.
module core_int_ctrl #(
  parameter int XLEN    = 64,
  parameter int NLOCAL  = 16,
  parameter int CAUSE_W = 6
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              irq_msip,
  input  logic              irq_mtip,
  input  logic              irq_meip,
  input  logic [NLOCAL-1:0] irq_local,
  input  logic [XLEN-1:0]   csr_mie,
  input  logic              mstatus_mie,
  input  logic              mode_m,
  input  logic [XLEN-1:0]   mtvec_base,
  input  logic              mtvec_vectored,
  input  logic              csr_mip_clr,
  input  logic [NLOCAL-1:0] csr_mip_clr_mask,
  output logic [XLEN-1:0]   mip,
  core_int_ctrl_if.master   wb
);

  typedef enum logic [1:0] {IDLE, OFFER, ACKED} state_t;

  state_t              r_state;
  logic [CAUSE_W-1:0]  r_cause;
  logic                r_msip, r_mtip, r_meip;
  logic [NLOCAL-1:0]   r_loc_sync, r_loc_prev, r_loc_pend;

  logic [XLEN-1:0]     w_mip, w_en;
  logic [NLOCAL-1:0]   w_loc_edge, w_loc_clr;
  logic [CAUSE_W-1:0]  w_winner;
  logic                w_global, w_locked, w_offer, w_take;
  logic [XLEN-1:0]     w_cause_ext;

  assign w_loc_edge = r_loc_sync & ~r_loc_prev;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_msip     <= 1'b0;
      r_mtip     <= 1'b0;
      r_meip     <= 1'b0;
      r_loc_sync <= '0;
      r_loc_prev <= '0;
      r_loc_pend <= '0;
    end else begin
      r_msip     <= irq_msip;
      r_mtip     <= irq_mtip;
      r_meip     <= irq_meip;
      r_loc_sync <= irq_local;
      r_loc_prev <= r_loc_sync;
      // A fresh edge overrides a same-cycle clear so that event is not lost.
      r_loc_pend <= (r_loc_pend & ~w_loc_clr) | w_loc_edge;
    end
  end

  always_comb begin
    w_mip                = '0;
    w_mip[3]             = r_msip;
    w_mip[7]             = r_mtip;
    w_mip[11]            = r_meip;
    w_mip[16 +: NLOCAL]  = r_loc_pend;
  end

  assign w_en     = w_mip & csr_mie;
  assign w_global = mstatus_mie || !mode_m;

  // Later assignments win, so the order below encodes ascending priority.
  always_comb begin
    w_winner = '0;
    for (int i = NLOCAL - 1; i >= 0; i--) begin
      if (w_en[16 + i]) w_winner = CAUSE_W'(16 + i);
    end
    if (w_en[7])  w_winner = CAUSE_W'(7);
    if (w_en[3])  w_winner = CAUSE_W'(3);
    if (w_en[11]) w_winner = CAUSE_W'(11);
  end

  always_comb begin
    w_locked = 1'b0;
    for (int i = 0; i < XLEN && i < (1 << CAUSE_W); i++) begin
      if (r_cause == CAUSE_W'(i)) w_locked = w_en[i];
    end
  end

  assign w_offer = (r_state == OFFER) && w_locked && w_global;
  assign w_take  = w_offer && wb.int_ack;

  always_comb begin
    w_loc_clr = '0;
    for (int i = 0; i < NLOCAL; i++) begin
      w_loc_clr[i] = (csr_mip_clr && csr_mip_clr_mask[i]) ||
                     (w_take && (r_cause == CAUSE_W'(16 + i)));
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= IDLE;
      r_cause <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_en && w_global) begin
            r_cause <= w_winner;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (!w_offer)          r_state <= IDLE;
          else if (wb.int_ack)   r_state <= ACKED;
        end
        ACKED:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_cause_ext    = XLEN'(r_cause);
  assign mip            = w_mip;
  assign wb.int_pending = |w_en;
  assign wb.int_request = w_offer;
  assign wb.int_cause   = r_cause;
  assign wb.int_tvec    = mtvec_vectored ? (mtvec_base + (w_cause_ext << 2)) : mtvec_base;

endmodule

// File: tb/tb_core_int_ctrl.sv
// Directed bench for core_int_ctrl: stimulus queues expected offers, and a
// negedge monitor checks each rising int_request against the queue.
module tb_core_int_ctrl;

  localparam int XLEN    = 64;
  localparam int NLOCAL  = 16;
  localparam int CAUSE_W = 6;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    tvec;
    int                 cyc;
  } exp_t;

  logic              g_clk = 1'b0;
  logic              g_reset;
  logic              irq_msip, irq_mtip, irq_meip;
  logic [NLOCAL-1:0] irq_local;
  logic [XLEN-1:0]   csr_mie;
  logic              mstatus_mie, mode_m;
  logic [XLEN-1:0]   mtvec_base;
  logic              mtvec_vectored;
  logic              csr_mip_clr;
  logic [NLOCAL-1:0] csr_mip_clr_mask;
  logic [XLEN-1:0]   mip;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   t;
  logic prevReq    = 1'b0;
  exp_t expQ[$];
  exp_t e;

  core_int_ctrl_if #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) wb ();

  core_int_ctrl #(.XLEN(XLEN), .NLOCAL(NLOCAL), .CAUSE_W(CAUSE_W)) dut (
    .g_clk            (g_clk),
    .g_reset          (g_reset),
    .irq_msip         (irq_msip),
    .irq_mtip         (irq_mtip),
    .irq_meip         (irq_meip),
    .irq_local        (irq_local),
    .csr_mie          (csr_mie),
    .mstatus_mie      (mstatus_mie),
    .mode_m           (mode_m),
    .mtvec_base       (mtvec_base),
    .mtvec_vectored   (mtvec_vectored),
    .csr_mip_clr      (csr_mip_clr),
    .csr_mip_clr_mask (csr_mip_clr_mask),
    .mip              (mip),
    .wb               (wb)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectOffer(input logic [CAUSE_W-1:0] cause, input logic [XLEN-1:0] tvec, input int at);
    exp_t x;
    x.cause = cause;
    x.tvec  = tvec;
    x.cyc   = at;
    expQ.push_back(x);
  endtask

  task automatic nextCycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge g_clk);
  endtask

  // Every new offer must match the oldest queued expectation, including its cycle.
  always @(negedge g_clk) begin
    if (!g_reset && wb.int_request && !prevReq) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_offer: cause %0d offered with nothing expected (cycle %0d)",
                 wb.int_cause, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("offer_cause", 64'(wb.int_cause), 64'(e.cause));
        checkOutput("offer_tvec", wb.int_tvec, e.tvec);
        checkOutput("offer_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prevReq = wb.int_request;
  end

  initial begin
    g_reset          = 1'b1;
    irq_msip         = 1'b0;
    irq_mtip         = 1'b0;
    irq_meip         = 1'b0;
    irq_local        = '0;
    csr_mie          = 64'h0000_0000_FFFF_0888;
    mstatus_mie      = 1'b1;
    mode_m           = 1'b1;
    mtvec_base       = BASE;
    mtvec_vectored   = 1'b0;
    csr_mip_clr      = 1'b0;
    csr_mip_clr_mask = '0;
    wb.int_ack       = 1'b0;

    nextCycle(); sample();
    checkOutput("rst_mip", mip, 64'h0);
    checkOutput("rst_pending", 64'(wb.int_pending), 64'h0);
    checkOutput("rst_request", 64'(wb.int_request), 64'h0);
    checkOutput("rst_cause", 64'(wb.int_cause), 64'h0);
    checkOutput("rst_tvec", wb.int_tvec, BASE);
    nextCycle(); g_reset = 1'b0;
    nextCycle(); nextCycle();

    // Timer interrupt, direct mode.
    nextCycle(); t = cyc; irq_mtip = 1'b1; expectOffer(7, BASE, t + 2);
    nextCycle(); sample();
    checkOutput("mtip_mip", mip, 64'h80);
    checkOutput("mtip_pending", 64'(wb.int_pending), 64'h1);
    checkOutput("mtip_req_early", 64'(wb.int_request), 64'h0);
    nextCycle(); wb.int_ack = 1'b1; irq_mtip = 1'b0; sample();
    nextCycle(); wb.int_ack = 1'b0; sample();
    checkOutput("mtip_acked_req", 64'(wb.int_request), 64'h0);
    nextCycle(); nextCycle();

    // Simultaneous sources, vectored mode: MEI, then MSI, then local 2.
    nextCycle(); t = cyc;
    mtvec_vectored = 1'b1; irq_meip = 1'b1; irq_msip = 1'b1; irq_local[2] = 1'b1;
    expectOffer(11, 64'h8000_002C, t + 2);
    nextCycle(); sample();
    checkOutput("multi_mip1", mip, 64'h808);
    nextCycle(); wb.int_ack = 1'b1; irq_meip = 1'b0; sample();
    checkOutput("multi_mip2", mip, 64'h4_0808);
    nextCycle(); wb.int_ack = 1'b0; expectOffer(3, 64'h8000_000C, t + 5); sample();
    checkOutput("multi_acked_req", 64'(wb.int_request), 64'h0);
    nextCycle(); sample();
    checkOutput("multi_idle_req", 64'(wb.int_request), 64'h0);
    nextCycle(); wb.int_ack = 1'b1; irq_msip = 1'b0; expectOffer(18, 64'h8000_0048, t + 8); sample();
    nextCycle(); wb.int_ack = 1'b0;
    nextCycle();
    nextCycle(); wb.int_ack = 1'b1; irq_local[2] = 1'b0; sample();
    checkOutput("multi_mip_local", mip, 64'h4_0000);
    nextCycle(); wb.int_ack = 1'b0; sample();
    checkOutput("multi_local_cleared", mip, 64'h0);
    nextCycle();

    // Local 0 single pulse, acked and cleared.
    nextCycle(); t = cyc; irq_local[0] = 1'b1; expectOffer(16, 64'h8000_0040, t + 3);
    nextCycle(); irq_local[0] = 1'b0; sample();
    checkOutput("loc0_mip_sync", mip, 64'h0);
    nextCycle(); sample();
    checkOutput("loc0_mip_set", mip, 64'h1_0000);
    nextCycle(); wb.int_ack = 1'b1; sample();
    checkOutput("loc0_mip_ackcyc", mip, 64'h1_0000);
    nextCycle(); wb.int_ack = 1'b0; sample();
    checkOutput("loc0_mip_clear", mip, 64'h0);
    nextCycle();

    // Local 0 edge landing in the ack cycle re-pends the bit.
    nextCycle(); t = cyc; irq_local[0] = 1'b1; expectOffer(16, 64'h8000_0040, t + 3);
    nextCycle(); irq_local[0] = 1'b0;
    nextCycle(); irq_local[0] = 1'b1;
    nextCycle(); wb.int_ack = 1'b1; expectOffer(16, 64'h8000_0040, t + 6); sample();
    nextCycle(); wb.int_ack = 1'b0; irq_local[0] = 1'b0; sample();
    checkOutput("repend_mip", mip, 64'h1_0000);
    checkOutput("repend_acked_req", 64'(wb.int_request), 64'h0);
    nextCycle();
    nextCycle(); wb.int_ack = 1'b1; sample();
    nextCycle(); wb.int_ack = 1'b0; sample();
    checkOutput("repend_mip_clear", mip, 64'h0);
    nextCycle();

    // Global gating: pending visible, no offer until user mode.
    nextCycle(); t = cyc; mstatus_mie = 1'b0; irq_meip = 1'b1;
    nextCycle(); sample();
    checkOutput("gate_pending", 64'(wb.int_pending), 64'h1);
    checkOutput("gate_mip", mip, 64'h800);
    nextCycle(); sample();
    checkOutput("gate_req_blocked", 64'(wb.int_request), 64'h0);
    nextCycle(); mode_m = 1'b0; expectOffer(11, 64'h8000_002C, t + 4); sample();
    checkOutput("gate_req_idle", 64'(wb.int_request), 64'h0);
    nextCycle(); wb.int_ack = 1'b1; irq_meip = 1'b0; sample();
    nextCycle(); wb.int_ack = 1'b0; mode_m = 1'b1; mstatus_mie = 1'b1;
    nextCycle(); nextCycle();

    // Timer withdrawn before ack, with a wrapping vectored address; late ack ignored.
    nextCycle(); t = cyc;
    mtvec_base = 64'hFFFF_FFFF_FFFF_FFF0; irq_mtip = 1'b1;
    expectOffer(7, 64'h0000_0000_0000_000C, t + 2);
    nextCycle();
    nextCycle(); irq_mtip = 1'b0; sample();
    checkOutput("drop_req_held", 64'(wb.int_request), 64'h1);
    nextCycle(); wb.int_ack = 1'b1; sample();
    checkOutput("drop_req_fell", 64'(wb.int_request), 64'h0);
    nextCycle(); wb.int_ack = 1'b0; sample();
    checkOutput("drop_req_after", 64'(wb.int_request), 64'h0);
    checkOutput("drop_pending", 64'(wb.int_pending), 64'h0);
    nextCycle();

    // Reset in the middle of an offer, sources still high afterwards.
    nextCycle(); t = cyc;
    mtvec_base = BASE; mtvec_vectored = 1'b0; irq_meip = 1'b1; irq_msip = 1'b1;
    expectOffer(11, BASE, t + 2);
    nextCycle();
    nextCycle(); sample();
    nextCycle(); g_reset = 1'b1; sample();
    checkOutput("midrst_request", 64'(wb.int_request), 64'h0);
    checkOutput("midrst_pending", 64'(wb.int_pending), 64'h0);
    checkOutput("midrst_mip", mip, 64'h0);
    checkOutput("midrst_cause", 64'(wb.int_cause), 64'h0);
    checkOutput("midrst_tvec", wb.int_tvec, BASE);
    nextCycle();
    nextCycle(); g_reset = 1'b0; expectOffer(11, BASE, t + 7); sample();
    checkOutput("postrst_req0", 64'(wb.int_request), 64'h0);
    nextCycle(); sample();
    checkOutput("postrst_mip", mip, 64'h808);
    checkOutput("postrst_req1", 64'(wb.int_request), 64'h0);
    nextCycle(); wb.int_ack = 1'b1; irq_meip = 1'b0; irq_msip = 1'b0; sample();
    nextCycle(); wb.int_ack = 1'b0;
    nextCycle(); nextCycle();

    // Software clear of a local pending bit while interrupts are masked.
    nextCycle(); mstatus_mie = 1'b0; irq_local[5] = 1'b1;
    nextCycle(); irq_local[5] = 1'b0;
    nextCycle(); sample();
    checkOutput("swclr_mip_set", mip, 64'h20_0000);
    csr_mip_clr = 1'b1; csr_mip_clr_mask = 16'h0020;
    nextCycle(); csr_mip_clr = 1'b0; csr_mip_clr_mask = '0; sample();
    checkOutput("swclr_mip_clear", mip, 64'h0);
    checkOutput("swclr_pending", 64'(wb.int_pending), 64'h0);
    mstatus_mie = 1'b1;
    nextCycle(); nextCycle(); nextCycle(); sample();

    checkOutput("queue_empty", 64'(expQ.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
